// File: rtl/gfx_bus_arbiter.sv
// gfx_bus_arbiter: round-robin sharing of the graphics ASIC register bus between CPU (port 0)
// and physics engine (port 1), one registered single-word read or write at a time.
module gfx_bus_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_frame_lock,
    output logic [1:0]        o_ack,
    output logic [1:0]        o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_chipselect,
    output logic              o_read,
    output logic [ADDR_W-1:0] o_data_address,
    inout  wire  [DATA_W-1:0] io_databus
);
    typedef enum logic [2:0] {IDLE, WR, RA, RW, DONE} state_t;
    localparam logic [ADDR_W:0] LP_NUM = NUM_REGS[ADDR_W:0];
    state_t              r_state, w_next;
    logic                r_last, r_g, r_cs, r_rd, r_oe;
    logic [1:0]          r_ack, r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic                w_g, w_start, w_bad;
    logic [ADDR_W-1:0]   w_addr;
    assign w_g     = (i_req == 2'b11) ? ~r_last : i_req[1];
    assign w_start = (r_state == IDLE) && (i_req != 2'b00) && !i_frame_lock;
    assign w_addr  = w_g ? i_addr1 : i_addr0;
    assign w_bad   = {1'b0, w_addr} >= LP_NUM;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_start ? IDLE : w_bad ? DONE : i_we[w_g] ? WR : RA;
            WR:      w_next = DONE;
            RA:      w_next = RW;
            RW:      w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    // Bus-facing outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_g     <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_oe    <= 1'b0;
            r_ack   <= 2'b00;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_g     <= w_g;
                r_last  <= w_g;
                r_wdata <= w_g ? i_wdata1 : i_wdata0;
                if (!w_bad) r_addr <= w_addr;
            end
            r_cs  <= (w_next == WR) || (w_next == RA);
            r_rd  <= w_next == RA;
            r_oe  <= w_next == WR;
            r_ack <= (r_state == WR || r_state == RW) ? (r_g ? 2'b10 : 2'b01) : 2'b00;
            r_err <= (w_start && w_bad) ? (w_g ? 2'b10 : 2'b01) : 2'b00;
            if (r_state == RW) r_rdata <= io_databus;
        end
    end
    assign io_databus     = r_oe ? r_wdata : 'z;
    assign o_ack          = r_ack;
    assign o_err          = r_err;
    assign o_rdata        = r_rdata;
    assign o_busy         = r_state != IDLE;
    assign o_chipselect   = r_cs;
    assign o_read         = r_rd;
    assign o_data_address = r_addr;
endmodule
